// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage definitions: datapath width, reset/bubble constants, FSM states.
package rv_fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// Fetch program counter: reset, redirect, hold on stall, otherwise advance by one word.
module pc_reg
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] programC
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_target_aligned;

    // Redirect targets are forced onto a word boundary; the low bits only feed the misaligned flag.
    assign w_target_aligned = branch_target & {{(XLEN-2){1'b1}}, 2'b00};

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        if (branch_taken) begin
            w_pc_next = w_target_aligned;
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign programC = r_pc;
endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID decode register, fetch counter and FILL/RUN tracking.
module pc_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] programC,
    input  logic [31:0] instr,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcPlus4D,
    output logic        validD,
    output logic        misaligned,
    output logic [31:0] fetch_count
);
    logic [31:0]  w_programC;
    logic [31:0]  w_pc_plus4;
    logic         w_load;
    logic         w_bubble;
    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0]  r_instrD;
    logic [31:0]  r_pcD;
    logic [31:0]  r_pcPlus4D;
    logic         r_validD;
    logic         r_misaligned;
    logic [31:0]  r_fetch_count;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .programC     (w_programC)
    );

    assign w_pc_plus4 = w_programC + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_load) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = FILL;
        endcase
    end

    // A redirect kills whatever is being fetched this cycle, even under stall.
    always_comb begin
        w_bubble = flush | branch_taken;
        w_load   = ~flush & ~branch_taken & ~stall;
    end

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= 32'd0;
            r_pcPlus4D <= 32'd0;
            r_validD   <= 1'b0;
        end else if (w_load) begin
            r_instrD   <= instr;
            r_pcD      <= w_programC;
            r_pcPlus4D <= w_pc_plus4;
            r_validD   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
            r_misaligned  <= 1'b0;
        end else begin
            if (w_load) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (branch_taken) begin
                r_misaligned <= |branch_target[1:0];
            end
        end
    end

    assign programC    = w_programC;
    assign instrD      = r_instrD;
    assign pcD         = r_pcD;
    assign pcPlus4D    = r_pcPlus4D;
    assign validD      = r_validD;
    assign misaligned  = r_misaligned;
    assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a cycle-level behavioural model, plus pinned scenarios.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] programC, instr, instrD, pcD, pcPlus4D, fetch_count;
    logic        validD, misaligned;
    logic [31:0] programC2, instr2, instrD2, pcD2, pcPlus4D2, fetch_count2;
    logic        validD2, misaligned2;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instrD;
        logic [31:0] pcD;
        logic [31:0] pcp4;
        logic [31:0] cnt;
        logic        valid;
        logic        mis;
    } mdl_t;

    mdl_t m1, m2;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0050_0093;
        return {a[15:0] ^ 16'h1234, a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    assign instr  = mem_word(programC);
    assign instr2 = mem_word(programC2);

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .programC(programC), .instr(instr), .instrD(instrD), .pcD(pcD),
        .pcPlus4D(pcPlus4D), .validD(validD), .misaligned(misaligned),
        .fetch_count(fetch_count)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .programC(programC2), .instr(instr2), .instrD(instrD2), .pcD(pcD2),
        .pcPlus4D(pcPlus4D2), .validD(validD2), .misaligned(misaligned2),
        .fetch_count(fetch_count2)
    );

    // One clock of the fetch stage described directly from its priority rules.
    function automatic mdl_t mdl_next(input mdl_t m, input logic r, st, fl, br,
                                      input logic [31:0] tg, input logic [31:0] rpc);
        mdl_t n;
        n = m;
        if (r) begin
            n.pc = rpc; n.instrD = 32'h13; n.pcD = 0; n.pcp4 = 0;
            n.valid = 0; n.mis = 0; n.cnt = 0;
            return n;
        end
        if (br)      n.pc = {tg[31:2], 2'b00};
        else if (!st) n.pc = m.pc + 32'd4;
        if (br) n.mis = (tg[1:0] != 2'b00);
        if (fl || br) begin
            n.instrD = 32'h13; n.pcD = 0; n.pcp4 = 0; n.valid = 0;
        end else if (!st) begin
            n.instrD = mem_word(m.pc); n.pcD = m.pc; n.pcp4 = m.pc + 32'd4;
            n.valid = 1; n.cnt = m.cnt + 32'd1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag, input mdl_t m,
                               input logic [31:0] a_pc, a_ins, a_pcd, a_p4, a_cnt,
                               input logic a_v, a_mis);
        check({tag, ".programC"},    a_pc,  m.pc);
        check({tag, ".instrD"},      a_ins, m.instrD);
        check({tag, ".pcD"},         a_pcd, m.pcD);
        check({tag, ".pcPlus4D"},    a_p4,  m.pcp4);
        check({tag, ".fetch_count"}, a_cnt, m.cnt);
        check({tag, ".validD"},      {31'd0, a_v},   {31'd0, m.valid});
        check({tag, ".misaligned"},  {31'd0, a_mis}, {31'd0, m.mis});
    endtask

    task automatic step(input logic r, st, fl, br, input logic [31:0] tg);
        mdl_t n1, n2;
        rst = r; stall = st; flush = fl; branch_taken = br; branch_target = tg;
        n1 = mdl_next(m1, r, st, fl, br, tg, 32'h0000_0000);
        n2 = mdl_next(m2, r, st, fl, br, tg, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        m1 = n1;
        m2 = n2;
        compare_all("u1", m1, programC, instrD, pcD, pcPlus4D, fetch_count, validD, misaligned);
        compare_all("u2", m2, programC2, instrD2, pcD2, pcPlus4D2, fetch_count2, validD2, misaligned2);
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 32'h40);
        check("rst.programC", programC, 32'h0);
        check("rst.instrD", instrD, 32'h13);
        check("rst.validD", {31'd0, validD}, 32'd0);

        // First fetch after reset release
        step(0, 0, 0, 0, 0);
        check("boot.instrD", instrD, 32'h0050_0093);
        check("boot.pcD", pcD, 32'h0);
        check("boot.pcPlus4D", pcPlus4D, 32'h4);
        check("boot.validD", {31'd0, validD}, 32'd1);
        check("boot.programC", programC, 32'h4);
        check("wrap.programC", programC2, 32'h0);
        check("wrap.pcD", pcD2, 32'hFFFF_FFFC);
        check("wrap.pcPlus4D", pcPlus4D2, 32'h0);
        step(0, 0, 0, 0, 0);
        check("boot.programC2", programC, 32'h8);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("pre_stall.programC", programC, 32'h10);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            check("stall.programC", programC, 32'h10);
            check("stall.pcD", pcD, 32'hC);
            check("stall.fetch_count", fetch_count, 32'd4);
        end
        step(0, 0, 0, 0, 0);
        check("resume.programC", programC, 32'h14);
        check("resume.pcD", pcD, 32'h10);

        step(0, 1, 0, 1, 32'h200);
        check("br_stall.programC", programC, 32'h200);
        check("br_stall.validD", {31'd0, validD}, 32'd0);
        check("br_stall.instrD", instrD, 32'h13);

        step(0, 0, 0, 1, 32'h203);
        check("mis.programC", programC, 32'h200);
        check("mis.flag", {31'd0, misaligned}, 32'd1);
        step(0, 0, 0, 0, 0);
        check("mis.hold", {31'd0, misaligned}, 32'd1);
        step(0, 0, 0, 1, 32'h100);
        check("mis.clear", {31'd0, misaligned}, 32'd0);
        step(0, 0, 0, 1, 32'h101);

        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        check("ten.programC", programC, 32'h128);
        step(1, 0, 1, 0, 0);
        check("rst2.programC", programC, 32'h0);
        check("rst2.fetch_count", fetch_count, 32'd0);
        check("rst2.misaligned", {31'd0, misaligned}, 32'd0);
        check("rst2.pcD", pcD, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic r, st, fl, br;
            logic [31:0] tg;
            r  = ($urandom_range(0, 63) == 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            br = ($urandom_range(0, 7) == 0);
            tg = $urandom;
            if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
            step(r, st, fl, br, tg);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013; addi x0,x0,0 bubble written into the decode register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard stall; hold PC and decode register.
REQ-006 flush  input  1  kill the instruction entering decode.
REQ-007 branch_taken  input  1  redirect request from execute.
REQ-008 branch_target  input  32  redirect byte address.
REQ-009 programC  output  32  current fetch PC, driven to instruction memory address input.
REQ-010 instr  input  32  little-endian word returned combinationally by instruction memory for programC.
REQ-011 instrD  output  32  registered instruction for decode.
REQ-012 pcD  output  32  registered PC of instrD.
REQ-013 pcPlus4D  output  32  registered pcD+4.
REQ-014 validD  output  1  instrD is a real fetched instruction.
REQ-015 misaligned  output  1  registered flag; last accepted redirect had target[1:0] != 0.
REQ-016 fetch_count  output  32  number of instructions accepted into decode since reset.

Function
REQ-017 programC SHALL be a register output; the instruction-memory read adds no cycle, so instr pairs with programC in the same cycle.
REQ-018 PC next-value priority SHALL be: rst -> RESET_PC; else branch_taken -> {branch_target[31:2],2'b00}; else stall -> hold; else programC+4.
REQ-019 branch_taken SHALL override stall for the PC (redirect never lost).
REQ-020 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flag.
REQ-021 misaligned SHALL update only on cycles with branch_taken=1, to (branch_target[1:0]!=0); held otherwise.
REQ-022 Decode register priority SHALL be: rst or flush or branch_taken -> bubble; else stall -> hold; else load.
REQ-023 Bubble: instrD=NOP_INSTR, pcD=0, pcPlus4D=0, validD=0.
REQ-024 Load: instrD=instr, pcD=programC, pcPlus4D=programC+4, validD=1.
REQ-025 flush together with stall SHALL produce a bubble (flush wins).
REQ-026 Latency: PC value P entering programC in cycle n appears on pcD in cycle n+1 if no stall/flush/redirect in cycle n.
REQ-027 fetch_count SHALL increment by 1 (modulo 2^32) on each load per REQ-024; unchanged on bubble or hold.
REQ-028 Block SHALL have two states: FILL (after reset, decode register holds bubble) and RUN; FILL -> RUN on first load; RUN -> FILL only on rst.
REQ-029 No combinational path from stall/flush/branch inputs to any output.

Reset
REQ-030 On rst=1 at a clock edge: programC=RESET_PC, instrD=NOP_INSTR, pcD=0, pcPlus4D=0, validD=0, misaligned=0, fetch_count=0, state=FILL.
REQ-031 rst asserted mid-operation SHALL override stall, flush and branch_taken in that cycle.
REQ-032 First cycle after rst deasserts SHALL fetch RESET_PC; validD=1 with pcD=RESET_PC one cycle later.

Structure
REQ-033 Shared package rv_fetch_pkg SHALL hold XLEN=32, NOP_INSTR constant, RESET_PC default and the FILL/RUN state enum.
REQ-034 PC update logic SHALL be a sub-module pc_reg (clk, rst, stall, branch_taken, branch_target -> programC); decode register and counter stay in pc_fetch_unit.

Verification
REQ-035 Reset release, memory word at 0 = 32'h00500093, no stalls -> cycle 1 programC=0; cycle 2 instrD=32'h00500093, pcD=0, pcPlus4D=4, validD=1, programC=8 next edge.
REQ-036 stall held 3 cycles at programC=32'h10 -> programC and instrD/pcD frozen 3 cycles, fetch_count unchanged, resumes at 32'h14.
REQ-037 branch_taken=1, branch_target=32'h200, stall=1 same cycle -> next programC=32'h200, validD=0, instrD=32'h00000013.
REQ-038 branch_target=32'h203 -> programC=32'h200, misaligned=1; next redirect to 32'h100 -> misaligned=0.
REQ-039 Force programC to 32'hFFFF_FFFC (RESET_PC) -> next programC=0, pcPlus4D=0 for that instruction.
REQ-040 rst pulsed after 10 loads with flush=1 -> all outputs at REQ-030 values, fetch_count=0.
